// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous-read data memory between
// the CPU load/store path and the DMA/debug port. Each access runs
// IDLE -> ACCESS -> RESP. The requester holds req until its one-cycle ready.
//
// state  | meaning
// IDLE   | arbitrate; a port is ignored in the cycle its ready is high
// ACCESS | exactly one memory strobe high, address/data from latched request
// RESP   | memory read data valid; winner's ready/rdata loaded on exit
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam bit RrEn = (RR != 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q;
  logic                last_dma_q;
  logic                win_dma_q;
  logic                we_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                cpu_ready_q;
  logic                dma_ready_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   dma_rdata_q;

  logic                cpu_elig;
  logic                dma_elig;
  logic                grant_dma_d;
  logic                sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;

  // A port completing this cycle is not eligible, so a held req starts a fresh access next IDLE.
  always_comb begin
    cpu_elig    = cpu_req & ~cpu_ready_q;
    dma_elig    = dma_req & ~dma_ready_q;
    grant_dma_d = dma_elig & (~cpu_elig | (RrEn & ~last_dma_q));
    sel_we_d    = grant_dma_d ? dma_we    : cpu_we;
    sel_addr_d  = grant_dma_d ? dma_addr  : cpu_addr;
    sel_wdata_d = grant_dma_d ? dma_wdata : cpu_wdata;
  end

  // Sequencer with registered strobes, readies and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_dma_q  <= 1'b1;
      win_dma_q   <= 1'b0;
      we_q        <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_elig || dma_elig) begin
            win_dma_q   <= grant_dma_d;
            last_dma_q  <= grant_dma_d;
            we_q        <= sel_we_d;
            mem_read_q  <= ~sel_we_d;
            mem_write_q <= sel_we_d;
            mem_addr_q  <= sel_addr_d;
            mem_wdata_q <= sel_wdata_d;
            state_q     <= ACCESS;
          end
        end
        ACCESS: state_q <= RESP;
        RESP: begin
          if (win_dma_q) begin
            dma_ready_q <= 1'b1;
            if (!we_q) dma_rdata_q <= mem_rdata;
          end else begin
            cpu_ready_q <= 1'b1;
            if (!we_q) cpu_rdata_q <= mem_rdata;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes are masked by reset so an access caught in ACCESS is never issued at the reset edge.
  assign mem_read  = mem_read_q  & ~reset;
  assign mem_write = mem_write_q & ~reset;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ready = cpu_ready_q;
  assign dma_ready = dma_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: two instances (round-robin and fixed
// priority) share the request inputs, each with its own synchronous memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

  logic [31:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_cpu_ready, a_dma_ready, a_mem_read, a_mem_write, a_busy;
  logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_cpu_ready, b_dma_ready, b_mem_read, b_mem_write, b_busy;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] shadow [64];
  logic [31:0] exp_cpu_rd, exp_dma_rd;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(1)) u_rr (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_ready(a_cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(a_dma_rdata), .dma_ready(a_dma_ready),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(0)) u_fp (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(b_dma_rdata), .dma_ready(b_dma_ready),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Synchronous-read word memories behind each arbiter.
  always @(posedge clk) begin
    if (a_mem_write) mem_a[a_mem_addr[7:2]] <= a_mem_wdata;
    if (a_mem_read)  a_mem_rdata <= mem_a[a_mem_addr[7:2]];
    if (b_mem_write) mem_b[b_mem_addr[7:2]] <= b_mem_wdata;
    if (b_mem_read)  b_mem_rdata <= mem_b[b_mem_addr[7:2]];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_cpu_rd = 32'h0;
    exp_dma_rd = 32'h0;
  endtask

  // One isolated access on the RR instance, cycle 0 = request cycle.
  task automatic run_single(input bit dma, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit churn);
    logic [5:0] idx;
    idx = addr[7:2];
    if (we) shadow[idx] = wdata;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      case (c)
        0: begin
          check_val("idle_busy", {31'b0, a_busy}, 32'd0);
          if (dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
          end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
          end
        end
        1: begin
          check_val("acc_read", {31'b0, a_mem_read}, {31'b0, !we});
          check_val("acc_write", {31'b0, a_mem_write}, {31'b0, we});
          check_val("acc_addr", a_mem_addr, addr);
          if (we) check_val("acc_wdata", a_mem_wdata, wdata);
          if (churn) begin
            cpu_addr = 32'h3C; cpu_wdata = 32'h0BAD0BAD;
            dma_addr = 32'h3C; dma_wdata = 32'h0BAD0BAD;
          end
        end
        2: begin
          check_val("resp_busy", {31'b0, a_busy}, 32'd1);
          check_val("resp_strobes", {30'b0, a_mem_read, a_mem_write}, 32'd0);
          check_val("resp_addr", a_mem_addr, addr);
          if (we) check_val("resp_wdata", a_mem_wdata, wdata);
        end
        3: begin
          if (!we) begin
            if (dma) exp_dma_rd = shadow[idx];
            else     exp_cpu_rd = shadow[idx];
          end
          check_val("rdy_cpu", {31'b0, a_cpu_ready}, {31'b0, !dma});
          check_val("rdy_dma", {31'b0, a_dma_ready}, {31'b0, dma});
          check_val("cpu_rdata", a_cpu_rdata, exp_cpu_rd);
          check_val("dma_rdata", a_dma_rdata, exp_dma_rd);
          check_val("rdy_busy", {31'b0, a_busy}, 32'd0);
          cpu_req = 1'b0; dma_req = 1'b0;
        end
        default: begin
          check_val("rdy_pulse", {30'b0, a_cpu_ready, a_dma_ready}, 32'd0);
          check_val("mem_content", mem_a[idx], shadow[idx]);
        end
      endcase
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    for (int i = 0; i < 64; i++) shadow[i] = 32'h0;
    exp_cpu_rd = 32'h0; exp_dma_rd = 32'h0;

    // reset values on both instances
    repeat (2) @(negedge clk);
    check_val("rst_busy", {30'b0, a_busy, b_busy}, 32'd0);
    check_val("rst_ready", {28'b0, a_cpu_ready, a_dma_ready, b_cpu_ready, b_dma_ready}, 32'd0);
    check_val("rst_strobe", {28'b0, a_mem_read, a_mem_write, b_mem_read, b_mem_write}, 32'd0);
    check_val("rst_cpu_rdata", a_cpu_rdata | b_cpu_rdata, 32'd0);
    check_val("rst_dma_rdata", a_dma_rdata | b_dma_rdata, 32'd0);
    check_val("rst_mem_addr", a_mem_addr | b_mem_addr, 32'd0);
    check_val("rst_mem_wdata", a_mem_wdata | b_mem_wdata, 32'd0);
    reset = 1'b0;

    // loader preloads through the DMA port
    run_single(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    run_single(1'b1, 1'b1, 32'h24, 32'h22222222, 1'b0);
    run_single(1'b1, 1'b1, 32'h20, 32'h11111111, 1'b0);
    run_single(1'b1, 1'b1, 32'h2C, 32'h5A5A5A5A, 1'b0);

    // CPU load
    run_single(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    check_val("cpu_load_val", exp_cpu_rd, 32'hDEADBEEF);

    // RR tie from reset: CPU, DMA, CPU, DMA
    reset_dut();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h24;
      end
      check_val("tie_cpu_rdy", {31'b0, a_cpu_ready}, {31'b0, (c == 3 || c == 9)});
      check_val("tie_dma_rdy", {31'b0, a_dma_ready}, {31'b0, (c == 6 || c == 12)});
      if (c == 1 || c == 7) check_val("tie_addr_cpu", a_mem_addr, 32'h20);
      if (c == 4 || c == 10) check_val("tie_addr_dma", a_mem_addr, 32'h24);
      if (c == 3) check_val("tie_cpu_rdata", a_cpu_rdata, 32'h11111111);
      if (c == 6) check_val("tie_dma_rdata", a_dma_rdata, 32'h22222222);
      if (c == 12) begin cpu_req = 1'b0; dma_req = 1'b0; end
      if (c == 13) check_val("tie_idle", {31'b0, a_busy}, 32'd0);
    end
    exp_cpu_rd = 32'h11111111;
    exp_dma_rd = 32'h22222222;

    // DMA write then CPU read of the same word
    run_single(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0);
    run_single(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
    check_val("dma_then_cpu", a_cpu_rdata, 32'h12345678);

    // requester churn during ACCESS
    run_single(1'b0, 1'b1, 32'h28, 32'hA5A5A5A5, 1'b1);

    // reset while a CPU write is in ACCESS, request held throughout
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check_val("rst_cpu_rdy", {31'b0, a_cpu_ready}, {31'b0, (c == 5)});
      case (c)
        0: begin
          cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h2C; cpu_wdata = 32'hCAFEF00D;
        end
        1: begin
          check_val("rst_acc_write", {31'b0, a_mem_write}, 32'd1);
          reset = 1'b1;
          #1;
          check_val("rst_write_gate", {31'b0, a_mem_write}, 32'd0);
        end
        2: begin
          check_val("rst_mid_busy", {31'b0, a_busy}, 32'd0);
          check_val("rst_mid_write", {31'b0, a_mem_write}, 32'd0);
          check_val("rst_mid_dma_rdy", {31'b0, a_dma_ready}, 32'd0);
          check_val("rst_mid_mem", mem_a[11], 32'h5A5A5A5A);
          check_val("rst_mid_mem_b", mem_b[11], 32'h5A5A5A5A);
          reset = 1'b0;
        end
        3: begin
          check_val("rst_reissue_wr", {31'b0, a_mem_write}, 32'd1);
          check_val("rst_reissue_addr", a_mem_addr, 32'h2C);
        end
        5: cpu_req = 1'b0;
        6: check_val("rst_after_mem", mem_a[11], 32'hCAFEF00D);
        default: ;
      endcase
    end

    // RR vs fixed priority once the CPU was the last grant
    reset_dut();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      check_val("pri_a_cpu_rdy", {31'b0, a_cpu_ready}, {31'b0, (c == 3)});
      check_val("pri_a_dma_rdy", {31'b0, a_dma_ready}, {31'b0, (c == 7 || c == 11)});
      check_val("pri_b_cpu_rdy", {31'b0, b_cpu_ready}, {31'b0, (c == 3 || c == 7)});
      check_val("pri_b_dma_rdy", {31'b0, b_dma_ready}, {31'b0, (c == 10)});
      case (c)
        0: begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; end
        3: cpu_req = 1'b0;
        4: begin
          cpu_req = 1'b1;
          dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h24;
        end
        5: begin
          check_val("pri_a_addr", a_mem_addr, 32'h24);
          check_val("pri_b_addr", b_mem_addr, 32'h10);
        end
        7: begin
          check_val("pri_a_dma_rdata", a_dma_rdata, 32'h22222222);
          check_val("pri_b_cpu_rdata", b_cpu_rdata, 32'hDEADBEEF);
          cpu_req = 1'b0;
        end
        10: begin
          check_val("pri_b_dma_rdata", b_dma_rdata, 32'h22222222);
          dma_req = 1'b0;
        end
        12: check_val("pri_idle", {30'b0, a_busy, b_busy}, 32'd0);
        default: ;
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
